// File: rtl/ccu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ccu_req_arbiter
// Description : Round-robin arbiter that grants one ACE master at a time a
//               whole read or write transaction towards the CCU FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module ccu_req_arbiter #(
    parameter int unsigned NoSlvPorts = 4,
    parameter type slv_req_t = struct packed {
        struct packed { logic [3:0] id; logic [31:0] addr; logic [1:0] len; } ar;
        logic ar_valid;
        struct packed { logic [3:0] id; logic [31:0] addr; logic [1:0] len; } aw;
        logic aw_valid;
        struct packed { logic [31:0] data; logic last; } w;
        logic w_valid;
        logic r_ready;
        logic b_ready;
    },
    parameter type slv_resp_t = struct packed {
        struct packed { logic [3:0] id; logic [31:0] data; logic last; } r;
        logic r_valid;
        struct packed { logic [3:0] id; logic [1:0] resp; } b;
        logic b_valid;
        logic ar_ready;
        logic aw_ready;
        logic w_ready;
    }
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  slv_req_t  slv_req_i  [NoSlvPorts],
    output slv_resp_t slv_resp_o [NoSlvPorts],
    output slv_req_t  ccu_req_o,
    input  slv_resp_t ccu_resp_i,
    output logic      busy_o,
    output logic [(NoSlvPorts > 1 ? $clog2(NoSlvPorts) : 1)-1:0] grant_idx_o
);

    localparam int unsigned IdxW = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_R = 2'd1;
    localparam logic [1:0] ST_GRANT_W = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [IdxW-1:0] grant_idx;
    logic [IdxW-1:0] grant_next;
    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] rr_next;
    logic [IdxW-1:0] rr_after;
    logic [IdxW-1:0] cand;
    logic            found;

    assign rr_after = (32'(grant_idx) == NoSlvPorts - 32'd1) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            grant_idx <= '0;
            rr_q      <= '0;
        end else begin
            state     <= state_next;
            grant_idx <= grant_next;
            rr_q      <= rr_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant_idx;
        rr_next    = rr_q;
        found      = 1'b0;
        cand       = '0;
        case (state)
            ST_IDLE: begin
                // Scan starts at the round-robin pointer; read wins over write on one port.
                for (int unsigned i = 0; i < NoSlvPorts; i++) begin
                    cand = IdxW'((32'(rr_q) + i) % NoSlvPorts);
                    if (!found && (slv_req_i[cand].ar_valid || slv_req_i[cand].aw_valid)) begin
                        found      = 1'b1;
                        grant_next = cand;
                        state_next = slv_req_i[cand].ar_valid ? ST_GRANT_R : ST_GRANT_W;
                    end
                end
            end
            ST_GRANT_R: begin
                if (ccu_resp_i.r_valid && ccu_resp_i.r.last && slv_req_i[grant_idx].r_ready) begin
                    state_next = ST_IDLE;
                    rr_next    = rr_after;
                end
            end
            ST_GRANT_W: begin
                if (ccu_resp_i.b_valid && slv_req_i[grant_idx].b_ready) begin
                    state_next = ST_IDLE;
                    rr_next    = rr_after;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ccu_req_o   = '0;
        busy_o      = 1'b0;
        grant_idx_o = '0;
        for (int unsigned i = 0; i < NoSlvPorts; i++) begin
            slv_resp_o[i] = '0;
        end
        case (state)
            ST_GRANT_R: begin
                busy_o                           = 1'b1;
                grant_idx_o                      = grant_idx;
                ccu_req_o                        = slv_req_i[grant_idx];
                ccu_req_o.aw_valid               = 1'b0;
                ccu_req_o.w_valid                = 1'b0;
                ccu_req_o.b_ready                = 1'b0;
                slv_resp_o[grant_idx]            = ccu_resp_i;
                slv_resp_o[grant_idx].aw_ready   = 1'b0;
                slv_resp_o[grant_idx].w_ready    = 1'b0;
                slv_resp_o[grant_idx].b_valid    = 1'b0;
            end
            ST_GRANT_W: begin
                busy_o                           = 1'b1;
                grant_idx_o                      = grant_idx;
                ccu_req_o                        = slv_req_i[grant_idx];
                ccu_req_o.ar_valid               = 1'b0;
                ccu_req_o.r_ready                = 1'b0;
                slv_resp_o[grant_idx]            = ccu_resp_i;
                slv_resp_o[grant_idx].ar_ready   = 1'b0;
                slv_resp_o[grant_idx].r_valid    = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ccu_req_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ccu_req_arbiter
// Description : Random ACE masters and CCU responder around the arbiter with a
//               transaction-level grant scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccu_req_arbiter;

    localparam int N = 4;

    typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [1:0] len; } ax_t;
    typedef struct packed { logic [31:0] data; logic last; } w_t;
    typedef struct packed { logic [3:0] id; logic [31:0] data; logic last; } r_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_t;
    typedef struct packed {
        ax_t ar; logic ar_valid; ax_t aw; logic aw_valid; w_t w; logic w_valid;
        logic r_ready; logic b_ready;
    } req_t;
    typedef struct packed {
        r_t r; logic r_valid; b_t b; logic b_valid;
        logic ar_ready; logic aw_ready; logic w_ready;
    } resp_t;
    typedef struct { int idx; bit rd; } grant_t;

    logic       clk = 1'b0;
    logic       rst;
    req_t       mreq  [N];
    resp_t      sresp [N];
    req_t       creq;
    resp_t      cresp;
    logic       busy;
    logic [1:0] gidx;

    ccu_req_arbiter #(.NoSlvPorts(N), .slv_req_t(req_t), .slv_resp_t(resp_t)) dut (
        .clk_i(clk), .rst_i(rst), .slv_req_i(mreq), .slv_resp_o(sresp),
        .ccu_req_o(creq), .ccu_resp_i(cresp), .busy_o(busy), .grant_idx_o(gidx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Master-side bookkeeping: 0 none, 1 valid held, 2 accepted/awaiting response
    int   ar_st [N];
    int   aw_st [N];
    bit   aw_acc [N];
    bit   w_acc [N];
    int   rbeats [N];
    bit   inj_ar [N];
    bit   inj_aw [N];
    logic [1:0] inj_len = 2'd0;
    bit   issue_en = 1'b0;

    bit   hs_ar [N], hs_r [N], hs_aw [N], hs_w [N], hs_b [N];
    logic s_rlast [N];
    logic [3:0] s_rid [N];
    logic [3:0] s_bid [N];

    int   rsp_rd_left = 0;
    logic [3:0] rsp_rid = '0;
    logic [3:0] rsp_bid = '0;
    bit   rsp_aw = 1'b0, rsp_w = 1'b0;
    bit   c_ar, c_aw, c_w, c_r, c_b;
    logic [1:0] c_len;
    logic [3:0] c_arid, c_awid;

    // Transaction-level reference: free flag, next start port, current owner
    bit     m_free = 1'b1;
    int     m_ptr = 0;
    int     m_idx = 0;
    bit     m_rd = 1'b0;
    grant_t exp_q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_bench();
        for (int i = 0; i < N; i++) begin
            mreq[i] = '0; ar_st[i] = 0; aw_st[i] = 0; aw_acc[i] = 0; w_acc[i] = 0;
            rbeats[i] = 0; inj_ar[i] = 0; inj_aw[i] = 0;
            hs_ar[i] = 0; hs_r[i] = 0; hs_aw[i] = 0; hs_w[i] = 0; hs_b[i] = 0;
        end
        cresp = '0; rsp_rd_left = 0; rsp_aw = 0; rsp_w = 0;
        c_ar = 0; c_aw = 0; c_w = 0; c_r = 0; c_b = 0;
        m_free = 1'b1; m_ptr = 0; m_idx = 0; exp_q.delete();
    endtask

    task automatic step();
        bit found;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (hs_ar[i]) begin ar_st[i] = 2; mreq[i].ar_valid = 1'b0; rbeats[i] = 0; end
            if (hs_r[i]) begin
                chk("r_beat_owner", 128'(ar_st[i]), 128'd2);
                chk("r_last", 128'(s_rlast[i]), 128'(rbeats[i] == int'(mreq[i].ar.len)));
                chk("r_id", 128'(s_rid[i]), 128'(mreq[i].ar.id));
                rbeats[i]++;
                if (s_rlast[i]) ar_st[i] = 0;
            end
            if (hs_aw[i]) begin aw_acc[i] = 1'b1; mreq[i].aw_valid = 1'b0; end
            if (hs_w[i])  begin w_acc[i] = 1'b1;  mreq[i].w_valid = 1'b0; end
            if (hs_b[i]) begin
                chk("b_id", 128'(s_bid[i]), 128'(mreq[i].aw.id));
                chk("b_after_aw_w", 128'(aw_acc[i] && w_acc[i]), 128'd1);
                aw_st[i] = 0;
            end
        end
        if (c_ar) begin rsp_rd_left = int'(c_len) + 1; rsp_rid = c_arid; end
        if (c_r) rsp_rd_left--;
        if (c_aw) begin rsp_aw = 1'b1; rsp_bid = c_awid; end
        if (c_w) rsp_w = 1'b1;
        if (c_b) begin rsp_aw = 1'b0; rsp_w = 1'b0; end

        for (int i = 0; i < N; i++) begin
            if (ar_st[i] == 0 && (inj_ar[i] || (issue_en && $urandom_range(3) == 0))) begin
                ar_st[i] = 1;
                mreq[i].ar_valid = 1'b1;
                mreq[i].ar.id    = 4'($urandom);
                mreq[i].ar.addr  = $urandom;
                mreq[i].ar.len   = inj_ar[i] ? inj_len : 2'($urandom);
                inj_ar[i] = 1'b0;
            end
            if (aw_st[i] == 0 && (inj_aw[i] || (issue_en && $urandom_range(3) == 0))) begin
                aw_st[i] = 1; aw_acc[i] = 1'b0; w_acc[i] = 1'b0;
                mreq[i].aw_valid = 1'b1;
                mreq[i].aw.id    = 4'($urandom);
                mreq[i].aw.addr  = $urandom;
                mreq[i].aw.len   = 2'd0;
                mreq[i].w_valid  = 1'b1;
                mreq[i].w.data   = $urandom;
                mreq[i].w.last   = 1'b1;
                inj_aw[i] = 1'b0;
            end
            mreq[i].r_ready = ($urandom_range(3) != 0);
            mreq[i].b_ready = ($urandom_range(3) != 0);
        end
        cresp.ar_ready = 1'($urandom);
        cresp.aw_ready = 1'($urandom);
        cresp.w_ready  = 1'($urandom);
        cresp.r_valid  = (rsp_rd_left > 0) && ($urandom_range(3) != 0);
        cresp.r.data   = $urandom;
        cresp.r.id     = rsp_rid;
        cresp.r.last   = (rsp_rd_left == 1);
        cresp.b_valid  = rsp_aw && rsp_w;
        cresp.b.id     = rsp_bid;
        cresp.b.resp   = 2'b00;

        #1;
        for (int i = 0; i < N; i++) begin
            hs_ar[i]   = mreq[i].ar_valid && sresp[i].ar_ready;
            hs_r[i]    = sresp[i].r_valid && mreq[i].r_ready;
            hs_aw[i]   = mreq[i].aw_valid && sresp[i].aw_ready;
            hs_w[i]    = mreq[i].w_valid && sresp[i].w_ready;
            hs_b[i]    = sresp[i].b_valid && mreq[i].b_ready;
            s_rlast[i] = sresp[i].r.last;
            s_rid[i]   = sresp[i].r.id;
            s_bid[i]   = sresp[i].b.id;
        end
        c_ar = creq.ar_valid && cresp.ar_ready; c_len = creq.ar.len; c_arid = creq.ar.id;
        c_aw = creq.aw_valid && cresp.aw_ready; c_awid = creq.aw.id;
        c_w  = creq.w_valid && cresp.w_ready;
        c_r  = cresp.r_valid && creq.r_ready;
        c_b  = cresp.b_valid && creq.b_ready;

        chk("busy", 128'(busy), 128'(!m_free));
        chk("grant_idx", 128'(gidx), 128'(m_free ? 0 : m_idx));
        if (m_free) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (!found && (mreq[p].ar_valid || mreq[p].aw_valid)) begin
                    found = 1'b1; m_free = 1'b0; m_idx = p; m_rd = mreq[p].ar_valid;
                    exp_q.push_back('{p, mreq[p].ar_valid});
                end
            end
        end else if (m_rd ? (cresp.r_valid && cresp.r.last && mreq[m_idx].r_ready)
                          : (cresp.b_valid && mreq[m_idx].b_ready)) begin
            m_free = 1'b1;
            m_ptr  = (m_idx + 1) % N;
        end
    endtask

    function automatic bit all_idle();
        bit r = m_free;
        for (int i = 0; i < N; i++)
            if (ar_st[i] != 0 || aw_st[i] != 0 || inj_ar[i] || inj_aw[i]) r = 1'b0;
        return r;
    endfunction

    task automatic drain();
        int n = 0;
        while (!all_idle() && n < 3000) begin step(); n++; end
        if (!all_idle()) begin
            checks++; failures++;
            $display("FAIL drain_timeout: actual=busy required=idle within 3000 cycles");
        end
        step(); step();
    endtask

    // Monitor: pops the expected grant when busy rises and checks routing every cycle
    initial begin
        grant_t cur;
        bit prev;
        cur = '{0, 1'b0};
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (busy && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL grant_unexpected: actual=port %0d required=no grant", gidx);
                end else begin
                    cur = exp_q.pop_front();
                    chk("grant_start_idx", 128'(gidx), 128'(cur.idx));
                    chk("grant_kind_ar", 128'(creq.ar_valid), 128'(cur.rd));
                    chk("grant_kind_aw", 128'(creq.aw_valid), 128'(!cur.rd));
                end
            end
            if (busy) begin
                for (int i = 0; i < N; i++)
                    if (i != cur.idx) chk("nongrant_resp_zero", 128'(sresp[i]), 128'd0);
                if (cur.rd) begin
                    chk("rd_fwd_ar", 128'({creq.ar, creq.ar_valid, creq.r_ready}),
                        128'({mreq[cur.idx].ar, mreq[cur.idx].ar_valid, mreq[cur.idx].r_ready}));
                    chk("rd_block_wr", 128'({creq.aw_valid, creq.w_valid, creq.b_ready}), 128'd0);
                    chk("rd_fwd_resp", 128'({sresp[cur.idx].r, sresp[cur.idx].r_valid, sresp[cur.idx].ar_ready}),
                        128'({cresp.r, cresp.r_valid, cresp.ar_ready}));
                    chk("rd_block_wresp", 128'({sresp[cur.idx].aw_ready, sresp[cur.idx].w_ready,
                        sresp[cur.idx].b_valid}), 128'd0);
                end else begin
                    chk("wr_fwd_aw", 128'({creq.aw, creq.aw_valid, creq.b_ready}),
                        128'({mreq[cur.idx].aw, mreq[cur.idx].aw_valid, mreq[cur.idx].b_ready}));
                    chk("wr_fwd_w", 128'({creq.w, creq.w_valid}), 128'({mreq[cur.idx].w, mreq[cur.idx].w_valid}));
                    chk("wr_block_rd", 128'({creq.ar_valid, creq.r_ready}), 128'd0);
                    chk("wr_fwd_resp", 128'({sresp[cur.idx].b, sresp[cur.idx].b_valid,
                        sresp[cur.idx].aw_ready, sresp[cur.idx].w_ready}),
                        128'({cresp.b, cresp.b_valid, cresp.aw_ready, cresp.w_ready}));
                    chk("wr_block_rresp", 128'({sresp[cur.idx].ar_ready, sresp[cur.idx].r_valid}), 128'd0);
                end
            end else begin
                chk("idle_creq_zero", 128'(creq), 128'd0);
                for (int i = 0; i < N; i++) chk("idle_resp_zero", 128'(sresp[i]), 128'd0);
            end
            prev = busy;
        end
    end

    initial begin
        #3_000_000;
        failures++;
        $display("FAIL watchdog: actual=still running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        clear_bench();
        #1;
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_gidx", 128'(gidx), 128'd0);
        chk("reset_creq", 128'(creq), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single read on port 2 from rr=0, then rr must point at 3
        inj_len = 2'd0; inj_ar[2] = 1'b1;
        drain();
        inj_ar[0] = 1'b1; inj_ar[3] = 1'b1;
        drain();
        // Read and write together on port 1: read first, write in a later round
        inj_ar[1] = 1'b1; inj_aw[1] = 1'b1;
        drain();
        // Three continuous readers
        inj_ar[0] = 1'b1; inj_ar[1] = 1'b1; inj_ar[3] = 1'b1;
        drain();

        issue_en = 1'b1;
        repeat (3000) step();
        issue_en = 1'b0;
        drain();

        // Reset in the middle of a 4-beat read on port 1
        inj_len = 2'd3; inj_ar[1] = 1'b1; rbeats[1] = 0;
        n = 0;
        while (!(ar_st[1] == 2 && rbeats[1] >= 2) && n < 500) begin step(); n++; end
        chk("rst_precond_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 128'(busy), 128'd0);
        chk("rst_mid_gidx", 128'(gidx), 128'd0);
        chk("rst_mid_creq", 128'(creq), 128'd0);
        for (int i = 0; i < N; i++) chk("rst_mid_resp", 128'(sresp[i]), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_bench();
        // rr must restart at 0
        inj_len = 2'd1; inj_ar[2] = 1'b1; inj_aw[0] = 1'b1;
        drain();

        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ccu_req_arbiter.md
CCU_REQ_ARBITER -- requirements
Module: ccu_req_arbiter

Interface
REQ-001 SHALL have parameter NoSlvPorts, default 4, number of requesting ACE masters (>=1).
REQ-002 SHALL have parameter slv_req_t, default logic, ACE request struct (ar/aw/w channels, valids, r_ready/b_ready).
REQ-003 SHALL have parameter slv_resp_t, default logic, ACE response struct (r/b channels, valids, ar/aw/w_ready).
REQ-004 SHALL have port clk_i  input  1  clock, all state rising-edge.
REQ-005 SHALL have port rst_i  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port slv_req_i  input  slv_req_t[NoSlvPorts]  requests from masters.
REQ-007 SHALL have port slv_resp_o  output  slv_resp_t[NoSlvPorts]  responses to masters.
REQ-008 SHALL have port ccu_req_o  output  slv_req_t  single request into CCU FSM.
REQ-009 SHALL have port ccu_resp_i  input  slv_resp_t  response from CCU FSM.
REQ-010 SHALL have port busy_o  output  1  high while a grant is held.
REQ-011 SHALL have port grant_idx_o  output  $clog2(NoSlvPorts) (min 1)  index of granted port, 0 when idle.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT_R, GRANT_W; registered state, registered grant index, registered round-robin pointer rr_q.
REQ-013 In IDLE: ccu_req_o='0, all slv_resp_o='0, busy_o=0; no ready is returned to any master.
REQ-014 In IDLE, arbitration SHALL scan ports rr_q, rr_q+1, ... wrapping mod NoSlvPorts; first port with ar_valid or aw_valid wins.
REQ-015 Winner with ar_valid=1 SHALL go to GRANT_R; winner with aw_valid=1 only SHALL go to GRANT_W (read beats write on the same port).
REQ-016 Grant SHALL be captured at the clock edge; forwarding starts the cycle after; request-to-ccu_req_o.ar_valid/aw_valid latency = 1 cycle.
REQ-017 GRANT_R: ccu_req_o = granted port's request with aw_valid, w_valid, b_ready forced 0; granted slv_resp_o = ccu_resp_i with aw_ready, w_ready, b_valid forced 0.
REQ-018 GRANT_W: ccu_req_o = granted port's request with ar_valid, r_ready forced 0; granted slv_resp_o = ccu_resp_i with ar_ready, r_valid forced 0.
REQ-019 Non-granted ports SHALL receive slv_resp_o='0 in every state.
REQ-020 GRANT_R release: cycle with ccu_resp_i.r_valid & r.last & granted r_ready -> IDLE; R beats without last keep grant.
REQ-021 GRANT_W release: cycle with ccu_resp_i.b_valid & granted b_ready -> IDLE.
REQ-022 On release, rr_q SHALL become (grant_idx+1) mod NoSlvPorts; NoSlvPorts=1 keeps rr_q=0.
REQ-023 Release cycle SHALL still forward the final handshake; IDLE always follows for exactly one cycle (one bubble) before the next grant.
REQ-024 A pending aw_valid on the granted read port SHALL be served only via a later arbitration round.
REQ-025 Requests from other ports during a grant SHALL be ignored (no ready) and retained by the masters per AXI valid-stability.
REQ-026 busy_o=1 and grant_idx_o=granted index in GRANT_R/GRANT_W.

Reset
REQ-027 rst_i=1 SHALL asynchronously force state IDLE, rr_q=0, grant index 0; all outputs '0 while asserted.
REQ-028 Reset mid-grant SHALL abandon the transaction; no partial handshake is completed after reset release.
REQ-029 After rst_i deasserts, first arbitration SHALL occur on the first rising edge with any valid.

Verification (NoSlvPorts=4)
REQ-030 Port 2 ar_valid in IDLE, rr_q=0 -> next cycle ccu_req_o.ar_valid=1, grant_idx_o=2; after r.last handshake -> IDLE, rr_q=3.
REQ-031 Ports 0,1,3 ar_valid continuously, rr_q=0 -> grant order 0,1,3,0; single-beat reads each; one idle cycle between grants.
REQ-032 Port 1 ar_valid and aw_valid together -> GRANT_R first; after release with rr_q=2, no other valids -> wrap to port 1, GRANT_W.
REQ-033 GRANT_W on port 0, port 3 aw_valid -> slv_resp_o[3]='0 throughout; b handshake -> grant_idx_o=3 two cycles later.
REQ-034 4-beat read on port 1, rst_i pulsed after beat 2 -> outputs '0 immediately, state IDLE, rr_q=0.
REQ-035 GRANT_R with r_valid, r.last=1, r_ready=0 for 3 cycles -> grant held; r_ready=1 -> release same edge.
